// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared widths and response-owner encoding for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int c_word_w  = 32;
    localparam int c_addr_w  = 16;
    localparam int c_cnt_w   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
// Module      : starve_counter
// Description : Saturating count of consecutive denied fetch cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module starve_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               clr,
    output logic [c_cnt_w-1:0] count,
    output logic               at_max
);

    localparam logic [c_cnt_w-1:0] c_max = c_cnt_w'(MAX);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count  = r_count;
    assign at_max = (r_count == c_max);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Fetch vs load/store arbiter for one single-port unified memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD       = c_word_w,
    parameter int ADDR       = c_addr_w,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [ADDR-1:0] if_addr,
    input  logic            if_flush,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [WORD-1:0] if_rdata,
    output logic            fetch_stall,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [ADDR-1:0] ls_addr,
    input  logic [WORD-1:0] ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [WORD-1:0] ls_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [ADDR-1:0] mem_addr,
    output logic [WORD-1:0] mem_wdata,
    input  logic [WORD-1:0] mem_rdata
);

    owner_t             r_owner;
    owner_t             w_owner_nxt;
    logic               r_drop;
    logic               w_at_max;
    logic               w_ls_win;
    logic [c_cnt_w-1:0] w_starve_cnt;

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (if_req & ~if_gnt),
        .clr    (if_gnt | ~if_req),
        .count  (w_starve_cnt),
        .at_max (w_at_max)
    );

    // Load/store wins unless fetch has been starved long enough.
    assign w_ls_win = ls_req & ~(w_at_max & if_req);

    // Every output is gated by reset so the block is silent while held in reset.
    always_comb begin
        if_gnt      = 1'b0;
        ls_gnt      = 1'b0;
        fetch_stall = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (reset) begin
            ls_gnt      = w_ls_win;
            if_gnt      = if_req & ~w_ls_win;
            fetch_stall = if_req & ~if_gnt;
            mem_en      = if_gnt | ls_gnt;
            mem_we      = ls_gnt & ls_we;
            if (ls_gnt) begin
                mem_addr = ls_addr;
            end else if (if_gnt) begin
                mem_addr = if_addr;
            end
            if (mem_we) begin
                mem_wdata = ls_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner <= IDLE;
            r_drop  <= 1'b0;
        end else begin
            r_owner <= w_owner_nxt;
            r_drop  <= if_gnt & if_flush;
        end
    end

    always_comb begin
        w_owner_nxt = IDLE;
        if (if_gnt) begin
            w_owner_nxt = IF_RD;
        end else if (ls_gnt && !ls_we) begin
            w_owner_nxt = LS_RD;
        end
    end

    // A fetch response is suppressed by a flush now or by one that hit its grant.
    always_comb begin
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;
        if (reset) begin
            if_rvalid = (r_owner == IF_RD) & ~if_flush & ~r_drop;
            ls_rvalid = (r_owner == LS_RD);
            if_rdata  = mem_rdata;
            ls_rdata  = mem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, ls_req, ls_we;
    logic [15:0] if_addr, ls_addr, mem_addr;
    logic [31:0] ls_wdata, if_rdata, ls_rdata, mem_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, fetch_stall, ls_gnt, ls_rvalid, mem_en, mem_we;

    logic [31:0] mem [0:65535];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WORD(32), .ADDR(16), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .fetch_stall(fetch_stall),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port synchronous-read memory
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    function automatic logic [31:0] init_val(input logic [15:0] a);
        return 32'hC0DE_0000 | {16'h0, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
        mem_rdata = '0;
        idle_inputs();
        reset = 1'b0;

        // Requests present during reset must produce nothing
        if_req = 1'b1; ls_req = 1'b1; if_addr = 16'h0001; ls_addr = 16'h0002;
        #2;
        chk("rst_if_gnt", 64'(if_gnt), 64'd0);
        chk("rst_ls_gnt", 64'(ls_gnt), 64'd0);
        chk("rst_stall", 64'(fetch_stall), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        cyc(); cyc();
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("rel_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);

        // Fetch only, addresses 0..3
        for (int a = 0; a < 4; a++) begin
            cyc();
            if_req = 1'b1; if_addr = 16'(a);
            #2;
            chk("fo_if_gnt", 64'(if_gnt), 64'd1);
            chk("fo_stall", 64'(fetch_stall), 64'd0);
            chk("fo_mem_addr", 64'(mem_addr), 64'(a));
            if (a > 0) begin
                chk("fo_rvalid", 64'(if_rvalid), 64'd1);
                chk("fo_rdata", 64'(if_rdata), 64'(init_val(16'(a - 1))));
            end
        end
        cyc();
        idle_inputs();
        #2;
        chk("fo_rvalid3", 64'(if_rvalid), 64'd1);
        chk("fo_rdata3", 64'(if_rdata), 64'(init_val(16'd3)));

        // Simultaneous fetch and load: load wins, fetch follows
        cyc();
        if_req = 1'b1; if_addr = 16'h0020;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0100; ls_wdata = 32'h1234_5678;
        #2;
        chk("sim_ls_gnt", 64'(ls_gnt), 64'd1);
        chk("sim_if_gnt", 64'(if_gnt), 64'd0);
        chk("sim_stall", 64'(fetch_stall), 64'd1);
        chk("sim_mem_addr", 64'(mem_addr), 64'h0100);
        chk("sim_wdata_ld", 64'(mem_wdata), 64'd0);
        chk("sim_mem_we", 64'(mem_we), 64'd0);
        cyc();
        ls_req = 1'b0;
        #2;
        chk("sim_ls_rvalid", 64'(ls_rvalid), 64'd1);
        chk("sim_ls_rdata", 64'(ls_rdata), 64'(init_val(16'h0100)));
        chk("sim_if_gnt2", 64'(if_gnt), 64'd1);
        chk("sim_if_rv0", 64'(if_rvalid), 64'd0);
        cyc();
        idle_inputs();
        #2;
        chk("sim_if_rvalid", 64'(if_rvalid), 64'd1);
        chk("sim_if_rdata", 64'(if_rdata), 64'(init_val(16'h0020)));
        chk("sim_ls_rv_off", 64'(ls_rvalid), 64'd0);

        // Starvation: fetch forced through on cycles 4 and 9
        for (int i = 0; i < 10; i++) begin
            cyc();
            if_req = 1'b1; if_addr = 16'h0030;
            ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'(16'h0040 + i);
            #2;
            chk($sformatf("stv_if_gnt%0d", i), 64'(if_gnt), 64'((i == 4) || (i == 9)));
            chk($sformatf("stv_ls_gnt%0d", i), 64'(ls_gnt), 64'((i != 4) && (i != 9)));
        end
        cyc();
        idle_inputs();
        #2;
        chk("stv_if_rvalid", 64'(if_rvalid), 64'd1);
        chk("stv_if_rdata", 64'(if_rdata), 64'(init_val(16'h0030)));

        // Store, then load back
        cyc();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0010; ls_wdata = 32'hDEAD_BEEF;
        #2;
        chk("st_gnt", 64'(ls_gnt), 64'd1);
        chk("st_mem_we", 64'(mem_we), 64'd1);
        chk("st_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        cyc();
        idle_inputs();
        #2;
        chk("st_no_rvalid", 64'(ls_rvalid), 64'd0);
        chk("st_we_off", 64'(mem_we), 64'd0);
        cyc();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0010;
        #2;
        chk("ldb_gnt", 64'(ls_gnt), 64'd1);
        cyc();
        idle_inputs();
        #2;
        chk("ldb_rvalid", 64'(ls_rvalid), 64'd1);
        chk("ldb_rdata", 64'(ls_rdata), 64'hDEAD_BEEF);

        // Flush in the response cycle
        cyc();
        if_req = 1'b1; if_addr = 16'h0005;
        #2;
        chk("fl_gnt", 64'(if_gnt), 64'd1);
        cyc();
        idle_inputs();
        if_flush = 1'b1;
        #2;
        chk("fl_rvalid", 64'(if_rvalid), 64'd0);
        cyc();
        if_flush = 1'b0; if_req = 1'b1; if_addr = 16'h0006;
        #2;
        chk("fl_next_gnt", 64'(if_gnt), 64'd1);
        cyc();
        if_req = 1'b1; if_addr = 16'h0007; if_flush = 1'b1;
        #2;
        chk("fl_next_rv", 64'(if_rvalid), 64'd0);
        chk("fl_gnt_on_fl", 64'(if_gnt), 64'd1);
        cyc();
        idle_inputs();
        #2;
        chk("fl_drop", 64'(if_rvalid), 64'd0);
        cyc();
        if_req = 1'b1; if_addr = 16'h0008;
        #2;
        chk("fl_after_gnt", 64'(if_gnt), 64'd1);
        cyc();
        idle_inputs();
        #2;
        chk("fl_after_rv", 64'(if_rvalid), 64'd1);
        chk("fl_after_rd", 64'(if_rdata), 64'(init_val(16'h0008)));

        // Reset while a load response is pending
        cyc();
        if_req = 1'b1; if_addr = 16'h0050;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0100;
        #2;
        chk("rm_ls_gnt", 64'(ls_gnt), 64'd1);
        cyc();
        idle_inputs();
        reset = 1'b0;
        #2;
        chk("rm_ls_rvalid", 64'(ls_rvalid), 64'd0);
        chk("rm_ls_rdata", 64'(ls_rdata), 64'd0);
        cyc();
        reset = 1'b1;
        #2;
        chk("rm_rel_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);
        chk("rm_rel_outs", 64'({if_gnt, ls_gnt, fetch_stall, mem_en, mem_we}), 64'd0);
        chk("rm_rel_cnt", 64'(dut.u_starve.count), 64'd0);
        // Counter restarted: a fresh contention denies fetch 4 times before forcing
        for (int i = 0; i < 5; i++) begin
            cyc();
            if_req = 1'b1; if_addr = 16'h0060;
            ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0200; ls_wdata = 32'h0;
            #2;
            chk($sformatf("rm_stv_if%0d", i), 64'(if_gnt), 64'(i == 4));
        end
        cyc();
        idle_inputs();
        #2;
        chk("rm_end_rvalid", 64'(if_rvalid), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one single-port, synchronous-read unified memory between the instruction-fetch stage and the load/store unit.
- Grants one access per cycle and routes each read response back to its requester one cycle later.
- Generates the fetch-side stall when fetch loses arbitration.
- A starvation counter guarantees that fetch makes forward progress under continuous load/store traffic.

Parameters:
WORD, 32, data/instruction width
ADDR, 16, word address width
STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced priority (legal range 1..15)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-low
if_req  input  1  fetch read request
if_addr  input  ADDR  fetch word address
if_flush  input  1  branch taken; discard any in-flight fetch response
if_gnt  output  1  fetch request accepted this cycle
if_rvalid  output  1  fetch read data valid
if_rdata  output  WORD  fetch read data
fetch_stall  output  1  if_req & ~if_gnt
ls_req  input  1  load/store request
ls_we  input  1  1 = store, 0 = load
ls_addr  input  ADDR  load/store word address
ls_wdata  input  WORD  store data
ls_gnt  output  1  load/store request accepted this cycle
ls_rvalid  output  1  load data valid
ls_rdata  output  WORD  load data
mem_en  output  1  memory access enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR  memory address
mem_wdata  output  WORD  memory write data
mem_rdata  input  WORD  memory read data, valid the cycle after a read with mem_en=1 and mem_we=0

Behaviour:
- Grant logic is combinational in the request cycle. At most one of if_gnt and ls_gnt is high per cycle.
- Default priority: ls over if. Exception: when starve_cnt == STARVE_MAX and if_req=1, fetch wins.
- Memory side: mem_en = if_gnt | ls_gnt. mem_we = ls_gnt & ls_we. mem_addr and mem_wdata are muxed from the winner. mem_wdata is 0 when the access is not a store. All mem_* outputs are 0 when idle.
- Response-owner register, states IDLE / IF_RD / LS_RD, updated every cycle:
  - if_gnt → IF_RD
  - ls_gnt with ls_we=0 → LS_RD
  - otherwise (store or no grant) → IDLE
- Read latency is exactly 1 cycle:
  - owner==IF_RD → if_rvalid=1
  - owner==LS_RD → ls_rvalid=1
  - if_rdata and ls_rdata both = mem_rdata combinationally; only the matching rvalid qualifies them.
- Stores produce no response.
- Flush handling:
  - if_flush=1 while owner==IF_RD forces if_rvalid=0 in that cycle.
  - if_flush=1 in the same cycle as an if_gnt sets a one-cycle drop flag, so the next cycle's if_rvalid is 0.
  - if_flush does not block a grant in its own cycle.
- Starvation counter (4 bits):
  - Increments when if_req & ~if_gnt.
  - Clears when if_gnt or ~if_req.
  - Saturates at STARVE_MAX.
- Back-to-back grants to either requester are legal every cycle. A new grant in the same cycle a response is returned is legal.
- Reset (asynchronous):
  - owner=IDLE, starve_cnt=0, drop flag=0.
  - All outputs 0 while reset is asserted, including fetch_stall.
  - A read in flight when reset asserts is lost; no rvalid follows reset deassertion.
- Requesters hold req/addr/data stable until granted. The arbiter does not register requests.

Decomposition:
- Shared package: WORD/ADDR defaults and the owner state encoding (IDLE=2'd0, IF_RD=2'd1, LS_RD=2'd2).
- One natural sub-module: starve_counter, a saturating counter with inc/clr/at_max.
- Grant mux and owner FSM stay in mem_arbiter.

Test Plan:
- Fetch only: if_req=1, addr 0..3 → if_gnt every cycle; if_rvalid 1 cycle later with mem[0..3]; fetch_stall=0 throughout.
- Simultaneous load: ls_req=1, ls_we=0, ls_addr=0x0100 with if_req=1 → ls_gnt=1, if_gnt=0, fetch_stall=1; next cycle ls_rvalid=1 with ls_rdata=mem[0x0100], if_gnt=1.
- Starvation: ls_req held high for 10 cycles, STARVE_MAX=4, with if_req=1 → if_gnt in cycles 4 and 9 only (0-based); ls_gnt in all other cycles.
- Store: ls_we=1, addr 0x0010, wdata 0xDEADBEEF → mem_we=1 for one cycle, no ls_rvalid; a later load of 0x0010 returns 0xDEADBEEF.
- Flush: if_flush=1 in the cycle after an if_gnt → if_rvalid=0 that cycle; the next granted fetch returns normally.
- Reset mid-read: assert reset the cycle after an ls load grant → ls_rvalid never asserts; after release all outputs are 0 and the counter is 0.
